mux_scan_accumulator: RTL and testbench



---
 rtl/mux_scan_accumulator_pkg.sv | 21 ++
 rtl/mux_scan_accumulator_if.sv | 26 ++
 rtl/mux_scan_accumulator_settle_timer.sv | 32 +++
 rtl/mux_scan_accumulator.sv | 130 +++++++++++++
 tb/tb_mux_scan_accumulator.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mux_scan_accumulator_pkg.sv
// Shared types, default sizes and the supply-threshold helper for the mux scan accumulator.
package mux_scan_pkg;

  localparam int N_CH_DEF  = 8;
  localparam int SEL_W_DEF = 3;
  localparam int DIN_W_DEF = 11;
  localparam int ACC_W_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A level reads as 1 only when it sits above VDD/2; with no supply nothing is high.
  function automatic logic vth(input logic v, input logic vdd);
    return v & vdd;
  endfunction

endpackage

// File: rtl/mux_scan_accumulator_if.sv
// Handshake and mux-side bus between the scan accumulator and its neighbours.
interface mux_scan_accumulator_if
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DIN_W = DIN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  logic             START;
  logic [DIN_W-1:0] DIN;
  logic [SEL_W-1:0] SEL;
  logic             BUSY;
  logic [ACC_W-1:0] SUM;
  logic             VALID;
  logic             READY;

  modport master (
    output START, DIN, READY,
    input  SEL, BUSY, SUM, VALID
  );

  modport slave (
    input  START, DIN, READY,
    output SEL, BUSY, SUM, VALID
  );
endinterface

// File: rtl/mux_scan_accumulator_settle_timer.sv
// Loadable 3-bit down-counter that times the mux settling window after each SEL change.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic CK,
  input  logic RSTN,
  input  logic LOAD,
  input  logic VDD,
  output logic DONE_T
);
  // Loading SETTLE-1 makes DONE_T assert on the SETTLE-th cycle spent waiting.
  localparam int          LOAD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [2:0]  LOAD_V = 3'(LOAD_I);

  logic [2:0] r_cnt;
  logic       w_load;

  assign w_load = vth(LOAD, VDD);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)
      r_cnt <= 3'd0;
    else if (w_load)
      r_cnt <= LOAD_V;
    else if (r_cnt != 3'd0)
      r_cnt <= r_cnt - 3'd1;
  end

  assign DONE_T = (r_cnt == 3'd0);
endmodule

// File: rtl/mux_scan_accumulator.sv
// Drives the 8:1 mux select, sums one sample per channel and hands the frame sum downstream.
module mux_scan_accumulator
  import mux_scan_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SETTLE = 1
) (
  input logic                  CK,
  input logic                  RSTN,
  input logic                  VDD,
  mux_scan_accumulator_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
  localparam state_t           ST_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_valid;

  logic             w_start;
  logic             w_ready;
  logic [DIN_W-1:0] w_din;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_last;
  logic             w_done_t;
  logic             w_load;
  logic             w_clr;
  logic             w_acc_en;
  logic             w_hs;

  assign w_start   = vth(bus.START, VDD);
  assign w_ready   = vth(bus.READY, VDD);
  assign w_din     = bus.DIN & {DIN_W{VDD}};
  assign w_acc_nxt = r_acc + ACC_W'(w_din);
  assign w_last    = (r_sel == LAST_SEL);
  assign w_hs      = (r_state == ST_DONE) && w_ready;

  scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .CK     (CK),
    .RSTN   (RSTN),
    .LOAD   (w_load),
    .VDD    (VDD),
    .DONE_T (w_done_t)
  );

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_clr    = 1'b0;
    w_acc_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_clr  = 1'b1;
          w_load = 1'b1;
          w_next = ST_FIRST;
        end
      end
      ST_SETTLE: begin
        if (w_done_t)
          w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_acc_en = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_load = 1'b1;
          w_next = ST_FIRST;
        end
      end
      ST_DONE: begin
        // A START coinciding with the handshake chains straight into the next frame.
        if (w_ready) begin
          if (w_start) begin
            w_clr  = 1'b1;
            w_load = 1'b1;
            w_next = ST_FIRST;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_sel   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_clr) begin
        r_sel <= '0;
        r_acc <= '0;
      end else if (w_acc_en) begin
        r_acc <= w_acc_nxt;
        if (!w_last)
          r_sel <= r_sel + SEL_W'(1);
      end
      // SUM is only ever rewritten by a completing frame, so it persists across handshakes.
      if (w_acc_en && w_last) begin
        r_sum   <= w_acc_nxt;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.SEL   = r_sel;
  assign bus.SUM   = r_sum;
  assign bus.VALID = r_valid;
  assign bus.BUSY  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mux_scan_accumulator.sv
// Directed bench: SETTLE=1 instance fed by a D_i=i+1 mux model, SETTLE=0 instance fed full-scale.
module tb_mux_scan_accumulator;
  logic CK;
  logic RSTN;
  logic VDD;
  int   n_vec;
  int   n_err;

  mux_scan_accumulator_if bus0 ();
  mux_scan_accumulator_if bus1 ();

  assign bus0.DIN = 11'(bus0.SEL) + 11'd1;
  assign bus1.DIN = 11'd2047;

  mux_scan_accumulator #(.SETTLE(1)) u0 (.CK(CK), .RSTN(RSTN), .VDD(VDD), .bus(bus0));
  mux_scan_accumulator #(.SETTLE(0)) u1 (.CK(CK), .RSTN(RSTN), .VDD(VDD), .bus(bus1));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; VDD = 1'b1;
    bus0.START = 1'b0; bus0.READY = 1'b0;
    bus1.START = 1'b0; bus1.READY = 1'b0;
    #12;
    n_vec++; if (bus0.SEL !== 3'd0) begin n_err++; $display("FAIL rst_sel got %0d want 0", bus0.SEL); end
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus0.VALID); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus0.BUSY); end
    n_vec++; if (bus0.SUM !== 14'd0) begin n_err++; $display("FAIL rst_sum got %0d want 0", bus0.SUM); end
    n_vec++; if (bus1.VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid1 got %b want 0", bus1.VALID); end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    bus0.READY = 1'b1;
    bus0.START = 1'b1;
    tick();
    bus0.START = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++; if (bus0.SEL !== 3'((k / 2 > 7) ? 7 : k / 2)) begin n_err++; $display("FAIL basic_sel k=%0d got %0d want %0d", k, bus0.SEL, (k / 2 > 7) ? 7 : k / 2); end
      n_vec++; if (bus0.VALID !== (k == 16)) begin n_err++; $display("FAIL basic_valid k=%0d got %b want %b", k, bus0.VALID, k == 16); end
      n_vec++; if (bus0.BUSY !== 1'b1) begin n_err++; $display("FAIL basic_busy k=%0d got %b want 1", k, bus0.BUSY); end
    end
    n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL basic_sum got %0d want 36", bus0.SUM); end
    tick();
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %b want 0", bus0.VALID); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %b want 0", bus0.BUSY); end
    n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL basic_sum_hold got %0d want 36", bus0.SUM); end
    n_vec++; if (bus0.SEL !== 3'd7) begin n_err++; $display("FAIL basic_sel_hold got %0d want 7", bus0.SEL); end
  endtask

  task automatic test_full_scale();
    bus1.READY = 1'b1;
    bus1.START = 1'b1;
    tick();
    bus1.START = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++; if (bus1.SEL !== 3'((k > 7) ? 7 : k)) begin n_err++; $display("FAIL fs_sel k=%0d got %0d want %0d", k, bus1.SEL, (k > 7) ? 7 : k); end
      n_vec++; if (bus1.VALID !== (k == 8)) begin n_err++; $display("FAIL fs_valid k=%0d got %b want %b", k, bus1.VALID, k == 8); end
    end
    n_vec++; if (bus1.SUM !== 14'd16376) begin n_err++; $display("FAIL fs_sum got %0d want 16376", bus1.SUM); end
    tick();
    n_vec++; if (bus1.VALID !== 1'b0) begin n_err++; $display("FAIL fs_valid_drop got %b want 0", bus1.VALID); end
  endtask

  task automatic test_backpressure();
    bus0.READY = 1'b0;
    bus0.START = 1'b1;
    tick();
    bus0.START = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    n_vec++; if (bus0.VALID !== 1'b1) begin n_err++; $display("FAIL bp_valid_rise got %b want 1", bus0.VALID); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_vec++; if (bus0.VALID !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold i=%0d got %b want 1", i, bus0.VALID); end
      n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL bp_sum_hold i=%0d got %0d want 36", i, bus0.SUM); end
      n_vec++; if (bus0.BUSY !== 1'b1) begin n_err++; $display("FAIL bp_busy i=%0d got %b want 1", i, bus0.BUSY); end
    end
    bus0.READY = 1'b1;
    tick();
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %b want 0", bus0.VALID); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got %b want 0", bus0.BUSY); end
  endtask

  task automatic test_ignored_start();
    int n_valid;
    n_valid = 0;
    bus0.READY = 1'b1;
    bus0.START = 1'b1;
    tick();
    for (int k = 1; k <= 24; k++) begin
      bus0.START = (k == 3 || k == 9);
      tick();
      if (bus0.VALID === 1'b1) n_valid++;
      n_vec++; if (bus0.VALID !== (k == 16)) begin n_err++; $display("FAIL ign_valid k=%0d got %b want %b", k, bus0.VALID, k == 16); end
      if (k == 16) begin
        n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL ign_sum got %0d want 36", bus0.SUM); end
      end
    end
    bus0.START = 1'b0;
    n_vec++; if (n_valid !== 1) begin n_err++; $display("FAIL ign_valid_count got %0d want 1", n_valid); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_err++; $display("FAIL ign_busy_end got %b want 0", bus0.BUSY); end
  endtask

  task automatic test_async_reset();
    bus0.READY = 1'b1;
    bus0.START = 1'b1;
    tick();
    bus0.START = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    n_vec++; if (bus0.SEL !== 3'd3) begin n_err++; $display("FAIL ar_pre_sel got %0d want 3", bus0.SEL); end
    RSTN = 1'b0;
    #1;
    n_vec++; if (bus0.SEL !== 3'd0) begin n_err++; $display("FAIL ar_sel got %0d want 0", bus0.SEL); end
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", bus0.VALID); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", bus0.BUSY); end
    #1;
    RSTN = 1'b1;
    tick();
    bus0.START = 1'b1;
    tick();
    bus0.START = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++; if (bus0.VALID !== (k == 16)) begin n_err++; $display("FAIL ar_valid k=%0d got %b want %b", k, bus0.VALID, k == 16); end
    end
    n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL ar_sum got %0d want 36", bus0.SUM); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus0.READY = 1'b0;
    bus0.START = 1'b1;
    tick();
    bus0.START = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    n_vec++; if (bus0.VALID !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got %b want 1", bus0.VALID); end
    bus0.START = 1'b1;
    bus0.READY = 1'b1;
    tick();
    bus0.START = 1'b0;
    bus0.READY = 1'b0;
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got %b want 0", bus0.VALID); end
    n_vec++; if (bus0.SEL !== 3'd0) begin n_err++; $display("FAIL b2b_sel got %0d want 0", bus0.SEL); end
    n_vec++; if (bus0.BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", bus0.BUSY); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++; if (bus0.VALID !== (k == 16)) begin n_err++; $display("FAIL b2b_valid k=%0d got %b want %b", k, bus0.VALID, k == 16); end
    end
    n_vec++; if (bus0.SUM !== 14'd36) begin n_err++; $display("FAIL b2b_sum got %0d want 36", bus0.SUM); end
    bus0.READY = 1'b1;
    tick();
    n_vec++; if (bus0.VALID !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got %b want 0", bus0.VALID); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic_frame();
    test_full_scale();
    test_backpressure();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
